// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - frame-paced sprite mover arbitrating pushbuttons against PS2 make codes
module move_arbiter #(
    parameter int STEP   = 4,
    parameter int X_MAX  = 624,
    parameter int Y_MAX  = 464,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       VGA_up,
    input  logic       VGA_down,
    input  logic       VGA_left,
    input  logic       VGA_right,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    input  logic       frame_tick,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       move_valid,
    output logic       move_src
);

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        CLAMP  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t state, state_next;

    // Button order in the vectors below: {up, down, left, right}
    logic [3:0] btn_meta, btn_sync, btn_pressed;
    logic       any_btn;

    logic       break_flag;
    logic       pend_valid;
    logic [1:0] pend_dir;
    logic       code_hit;
    logic [1:0] code_dir;
    logic       make_strobe;
    logic       ps2_clear;

    logic arb_valid, arb_src, arb_xp, arb_xn, arb_yp, arb_yn;
    logic req_valid, req_src, req_xp, req_xn, req_yp, req_yn;

    logic [10:0] x_ext, x_sum, x_dif, y_ext, y_sum, y_dif;
    logic [9:0]  next_x;
    logic [8:0]  next_y;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            btn_meta <= 4'hF;
            btn_sync <= 4'hF;
        end else begin
            btn_meta <= {VGA_up, VGA_down, VGA_left, VGA_right};
            btn_sync <= btn_meta;
        end
    end

    assign btn_pressed = ~btn_sync;
    assign any_btn     = |btn_pressed;

    always_comb begin
        code_hit = 1'b1;
        code_dir = DIR_UP;
        case (ps2_key_data)
            8'h1D:   code_dir = DIR_UP;
            8'h1B:   code_dir = DIR_DOWN;
            8'h1C:   code_dir = DIR_LEFT;
            8'h23:   code_dir = DIR_RIGHT;
            default: code_hit = 1'b0;
        endcase
    end

    assign make_strobe = ps2_key_pressed && !break_flag && code_hit;
    assign ps2_clear   = (state == ARB) && !any_btn && pend_valid;

    // A fresh make code takes priority over the clear issued when PS2 is served.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            break_flag <= 1'b0;
            pend_valid <= 1'b0;
            pend_dir   <= DIR_UP;
        end else begin
            if (ps2_key_pressed) begin
                if (break_flag)
                    break_flag <= 1'b0;
                else if (ps2_key_data == 8'hF0)
                    break_flag <= 1'b1;
            end
            if (make_strobe) begin
                pend_valid <= 1'b1;
                pend_dir   <= code_dir;
            end else if (ps2_clear) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        arb_valid = 1'b0;
        arb_src   = 1'b0;
        arb_xp    = 1'b0;
        arb_xn    = 1'b0;
        arb_yp    = 1'b0;
        arb_yn    = 1'b0;
        if (any_btn) begin
            arb_valid = 1'b1;
            arb_yn    = btn_pressed[3] && !btn_pressed[2];
            arb_yp    = btn_pressed[2] && !btn_pressed[3];
            arb_xn    = btn_pressed[1] && !btn_pressed[0];
            arb_xp    = btn_pressed[0] && !btn_pressed[1];
        end else if (pend_valid) begin
            arb_valid = 1'b1;
            arb_src   = 1'b1;
            arb_yn    = (pend_dir == DIR_UP);
            arb_yp    = (pend_dir == DIR_DOWN);
            arb_xn    = (pend_dir == DIR_LEFT);
            arb_xp    = (pend_dir == DIR_RIGHT);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick) state_next = ARB;
            ARB:     state_next = CLAMP;
            CLAMP:   state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            req_valid <= 1'b0;
            req_src   <= 1'b0;
            req_xp    <= 1'b0;
            req_xn    <= 1'b0;
            req_yp    <= 1'b0;
            req_yn    <= 1'b0;
        end else if (state == ARB) begin
            req_valid <= arb_valid;
            req_src   <= arb_src;
            req_xp    <= arb_xp;
            req_xn    <= arb_xn;
            req_yp    <= arb_yp;
            req_yn    <= arb_yn;
        end
    end

    // Bit 10 of the difference flags an underflow below zero.
    always_comb begin
        x_ext  = {1'b0, pos_x};
        y_ext  = {2'b00, pos_y};
        x_sum  = x_ext + STEP_W;
        x_dif  = x_ext - STEP_W;
        y_sum  = y_ext + STEP_W;
        y_dif  = y_ext - STEP_W;
        next_x = pos_x;
        next_y = pos_y;
        if (req_xn)
            next_x = x_dif[10] ? 10'd0 : 10'(x_dif);
        else if (req_xp)
            next_x = (x_sum > X_MAX_W) ? 10'(X_MAX_W) : 10'(x_sum);
        if (req_yn)
            next_y = y_dif[10] ? 9'd0 : 9'(y_dif);
        else if (req_yp)
            next_y = (y_sum > Y_MAX_W) ? 9'(Y_MAX_W) : 9'(y_sum);
    end

    // Outputs are registered on the CLAMP->COMMIT edge so they are visible during COMMIT.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pos_x      <= 10'(X_INIT);
            pos_y      <= 9'(Y_INIT);
            move_valid <= 1'b0;
            move_src   <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            if (state == CLAMP && req_valid) begin
                pos_x      <= next_x;
                pos_y      <= next_y;
                move_src   <= req_src;
                move_valid <= 1'b1;
            end
        end
    end

endmodule
